// File: rtl/sap_pkg.sv
// Shared definitions for the SAP host input port.
// Latency: n/a (types and defaults only).
// Backpressure: n/a.
package sap_pkg;

    localparam int DW_DEF    = 8;
    localparam int DEPTH_DEF = 4;

    typedef logic [DW_DEF-1:0] byte_t;

endpackage

// File: rtl/sap_sync2.sv
// Two-flop synchronizer bringing an asynchronous level into the CLK domain.
// Latency: 2 CLK cycles from input change to q.
// Backpressure: none; a plain level follower.
module sap_sync2 (
    input  logic CLK,
    input  logic RST,
    input  logic d,
    output logic q
);

    logic meta;

    // Metastability filter: first flop may go metastable, second resolves it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/sap_input_port.sv
// Host input port: strobe-captured bytes queued in a FWFT FIFO read by the CPU.
// Latency: strobe rise -> cpu_valid in 4 CLK cycles (2 sync, 1 edge detect, 1 write).
// Backpressure: ext_busy while full; a capture while full without a pop is dropped and sets ovf.
// Optional feature: define SAP_INPORT_PARITY_EN for ext_parity/perr (even parity check).
module sap_input_port import sap_pkg::*; #(
    parameter int DEPTH = DEPTH_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [DW-1:0] ext_data,
    input  logic          ext_strobe,
`ifdef SAP_INPORT_PARITY_EN
    input  logic          ext_parity,
    output logic          perr,
`endif
    output logic          ext_busy,
    input  logic          cpu_rd,
    output logic [DW-1:0] cpu_data,
    output logic          cpu_valid,
    output logic          ovf,
    input  logic          clr_ovf
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic          strobe_sync;
    logic          strobe_seen;
    logic [1:0]    settle;
    logic          strobe_rise;
    logic          cap_pulse;
    logic [DW-1:0] cap_data;
`ifdef SAP_INPORT_PARITY_EN
    logic          cap_par;
`endif

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          full;
    logic          par_ok;
    logic          do_pop;
    logic          do_push;
    logic          drop_full;

    sap_sync2 u_sync (
        .CLK (CLK),
        .RST (RST),
        .d   (ext_strobe),
        .q   (strobe_sync)
    );

    assign strobe_rise = strobe_sync & ~strobe_seen;

    // Edge detector: strobe_seen starts "high-seen" and only follows the
    // synchronizer once its reset zeros have flushed out, so a strobe held
    // high through reset must go low before it can be captured again.
    always_ff @(posedge CLK) begin
        if (RST) begin
            settle      <= 2'b00;
            strobe_seen <= 1'b1;
            cap_pulse   <= 1'b0;
            cap_data    <= '0;
`ifdef SAP_INPORT_PARITY_EN
            cap_par     <= 1'b0;
`endif
        end else begin
            settle    <= {settle[0], 1'b1};
            if (settle[1]) begin
                strobe_seen <= strobe_sync;
            end
            cap_pulse <= strobe_rise;
            // Host data is guaranteed stable here, so latch it with the pulse.
            if (strobe_rise) begin
                cap_data <= ext_data;
`ifdef SAP_INPORT_PARITY_EN
                cap_par  <= ext_parity;
`endif
            end
        end
    end

`ifdef SAP_INPORT_PARITY_EN
    assign par_ok = ~^{cap_par, cap_data};
`else
    assign par_ok = 1'b1;
`endif

    assign full      = (count == CW'(DEPTH));
    assign do_pop    = cpu_rd & cpu_valid;
    assign do_push   = cap_pulse & par_ok & (~full | do_pop);
    assign drop_full = cap_pulse & par_ok & full & ~do_pop;

    // Occupancy after this cycle's push/pop; feeds the registered status flags.
    always_comb begin
        count_next = count;
        case ({do_push, do_pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // FIFO control, status flags and sticky error flags (set beats clear).
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            cpu_valid <= 1'b0;
            ext_busy  <= 1'b0;
            ovf       <= 1'b0;
`ifdef SAP_INPORT_PARITY_EN
            perr      <= 1'b0;
`endif
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count     <= count_next;
            cpu_valid <= (count_next != '0);
            ext_busy  <= (count_next == CW'(DEPTH));
            if (drop_full) begin
                ovf <= 1'b1;
            end else if (clr_ovf) begin
                ovf <= 1'b0;
            end
`ifdef SAP_INPORT_PARITY_EN
            if (cap_pulse && !par_ok) begin
                perr <= 1'b1;
            end else if (clr_ovf) begin
                perr <= 1'b0;
            end
`endif
        end
    end

    // Storage has no reset; cpu_data is masked while the FIFO is empty.
    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem[wr_ptr] <= cap_data;
        end
    end

    assign cpu_data = cpu_valid ? mem[rd_ptr] : '0;

endmodule
